mod_mem_arbiter: RTL and testbench
==================================

Name: mod_mem_arbiter

Overview:
- Arbitrates one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RISC-V core.
- Grants one access at a time, and the data port has fixed priority.
- Latches the request, holds the memory handshake until the memory acknowledges, and returns a one-cycle acknowledge to the winning requester.
- A watchdog aborts accesses the memory never acknowledges.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
TIMEOUT, 16, maximum cycles an access may wait for mem_ack_i before being aborted (must be at least 2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; held high until if_ack_o
if_addr_i  in  ADDR_WIDTH  fetch address; stable while if_req_i is high
if_rdata_o  out  DATA_WIDTH  fetched instruction; valid when if_ack_o is high
if_ack_o  out  1  one-cycle fetch completion pulse
if_err_o  out  1  one-cycle pulse with if_ack_o when the fetch timed out
dm_req_i  in  1  data request (driven from mem_read_en/mem_write_en); held high until dm_ack_o
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  ADDR_WIDTH  data address
dm_wdata_i  in  DATA_WIDTH  store data
dm_rdata_o  out  DATA_WIDTH  load data; valid when dm_ack_o is high
dm_ack_o  out  1  one-cycle data completion pulse
dm_err_o  out  1  one-cycle pulse with dm_ack_o when the data access timed out
mem_req_o  out  1  memory access request; held until mem_ack_i or abort
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data; valid with mem_ack_i
mem_ack_i  in  1  memory completion; one-cycle pulse at any latency of 1 or more
busy_o  out  1  high while an access is outstanding (state not IDLE)

Behaviour:
- Reset:
  - rst_ni low forces, asynchronously, state IDLE and the timeout counter to 0.
  - All outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, both ack/err outputs, both rdata outputs, busy_o.
  - Reset mid-access drops the access silently; no ack is generated.
- FSM states: IDLE, BUSY_DM, BUSY_IF.
- IDLE, data request:
  - A requester is eligible when its req is high and its own ack output is low in the current cycle. This suppresses re-grant in the cycle the requester sees its ack.
  - If the data port is eligible: at the edge, latch dm_addr_i, dm_we_i and dm_wdata_i into the mem_* outputs, set mem_req_o=1, and go to BUSY_DM.
- IDLE, fetch request:
  - Otherwise, if the fetch port is eligible: latch if_addr_i, set mem_we_o=0, mem_wdata_o=0, mem_req_o=1, and go to BUSY_IF.
  - When both are eligible, data always wins. The MEM stage is older, so this avoids deadlock with a stalled pipeline.
- BUSY_x:
  - The mem_* outputs are held constant and the counter increments each cycle.
  - When mem_ack_i=1: at the edge, mem_req_o=0, state returns to IDLE, x_ack_o=1 for one cycle, and the counter clears.
  - For a read, x_rdata_o is captured from mem_rdata_i. For a write, dm_rdata_o holds its previous value.
- Timeout:
  - If the counter equals TIMEOUT-1 and mem_ack_i=0, abort at the edge: mem_req_o=0, state returns to IDLE, x_ack_o=1 and x_err_o=1 for one cycle, x_rdata_o=0, and the counter clears.
  - If mem_ack_i arrives in the same cycle as the timeout condition, the ack wins and no error is raised.
- mem_ack_i while in IDLE is ignored.
- Latency: request sampled at edge 0; mem_req_o high after edge 0; mem_ack_i at cycle k gives ack_o in the cycle after edge k+1. Best case is request to ack_o in 2 cycles.
- Back-to-back accesses: a new grant can occur in the cycle ack_o is high, but only to the other requester. The same requester is re-granted no earlier than the following cycle.
- Outputs other than the rdata and mem_* buses are registered pulses or levels; none are combinational from inputs.
- x_rdata_o holds its value between acks.

Test Plan:
- Fetch only: if_addr=0x0000_0010, mem_ack after 3 cycles with rdata=0x0000_0013 -> mem_addr_o=0x10 and mem_we_o=0 while mem_req_o=1; if_ack_o pulses once; if_rdata_o=0x13; busy_o drops.
- Simultaneous requests: if_req and dm_req (store, addr 0x100, wdata 0xDEADBEEF) rise in the same cycle -> the store is issued first with mem_we_o=1; the fetch is issued in the cycle dm_ack_o pulses; if_ack_o follows its own mem_ack.
- Load then store back-to-back on the data port, each with mem_ack latency 1 -> each access takes 2 cycles from grant to dm_ack_o, with one idle cycle between grants; dm_rdata_o keeps the load value through the store ack.
- Timeout: fetch issued, mem_ack_i never asserted, TIMEOUT=16 -> exactly 16 cycles of mem_req_o=1, then if_ack_o=if_err_o=1 for one cycle, if_rdata_o=0, state IDLE.
- Ack and timeout coincident: mem_ack_i in the 16th busy cycle -> normal ack, if_err_o=0, read data captured.
- Reset mid-access: rst_ni pulled low asynchronously between clock edges while in BUSY_DM -> all outputs 0 immediately; after release, no dm_ack_o until a fresh request completes.

Source files
------------

// File: rtl/mod_mem_arbiter_if.sv
// Bundles the fetch, data and memory handshakes of the unified-memory arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface mod_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_ack_o;
  logic                  if_err_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic [DATA_WIDTH-1:0] dm_rdata_o;
  logic                  dm_ack_o;
  logic                  dm_err_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  logic                  busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o, if_err_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ack_o, dm_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o, if_err_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ack_o, dm_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  busy_o
  );
endinterface

// File: rtl/mod_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data port has fixed priority; a watchdog aborts accesses the memory never acknowledges.
module mod_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mod_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_DM = 2'd1,
    BUSY_IF = 2'd2
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [DATA_WIDTH-1:0] if_rdata_r;
  logic                  if_ack_r;
  logic                  if_err_r;
  logic [DATA_WIDTH-1:0] dm_rdata_r;
  logic                  dm_ack_r;
  logic                  dm_err_r;
  logic                  busy_r;

  // A requester seeing its own ack this cycle is not re-granted until the next one.
  logic dm_elig_s;
  logic if_elig_s;
  logic timeout_s;
  logic done_s;

  assign dm_elig_s = bus.dm_req_i & ~dm_ack_r;
  assign if_elig_s = bus.if_req_i & ~if_ack_r;
  assign timeout_s = (cnt_r == CNT_LAST);
  assign done_s    = bus.mem_ack_i | timeout_s;

  // Arbitration FSM, watchdog counter and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      if_ack_r    <= 1'b0;
      if_err_r    <= 1'b0;
      dm_rdata_r  <= '0;
      dm_ack_r    <= 1'b0;
      dm_err_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if_ack_r <= 1'b0;
      if_err_r <= 1'b0;
      dm_ack_r <= 1'b0;
      dm_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (dm_elig_s) begin
            state_r     <= BUSY_DM;
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.dm_we_i;
            mem_addr_r  <= bus.dm_addr_i;
            mem_wdata_r <= bus.dm_wdata_i;
            busy_r      <= 1'b1;
          end else if (if_elig_s) begin
            state_r     <= BUSY_IF;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= bus.if_addr_i;
            mem_wdata_r <= '0;
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY_DM, BUSY_IF: begin
          if (done_s) begin
            // An ack coinciding with the last watchdog cycle still counts as success.
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= '0;
            if (state_r == BUSY_DM) begin
              dm_ack_r <= 1'b1;
              dm_err_r <= ~bus.mem_ack_i;
              if (!bus.mem_ack_i) begin
                dm_rdata_r <= '0;
              end else if (!mem_we_r) begin
                dm_rdata_r <= bus.mem_rdata_i;
              end else begin
                dm_rdata_r <= dm_rdata_r;
              end
            end else begin
              if_ack_r   <= 1'b1;
              if_err_r   <= ~bus.mem_ack_i;
              if_rdata_r <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_r;
  assign bus.mem_we_o    = mem_we_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wdata_o = mem_wdata_r;
  assign bus.if_rdata_o  = if_rdata_r;
  assign bus.if_ack_o    = if_ack_r;
  assign bus.if_err_o    = if_err_r;
  assign bus.dm_rdata_o  = dm_rdata_r;
  assign bus.dm_ack_o    = dm_ack_r;
  assign bus.dm_err_o    = dm_err_r;
  assign bus.busy_o      = busy_r;
endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Self-checking bench for mod_mem_arbiter: directed scenarios plus randomized
// fetch/data traffic checked against a transaction-level memory and arbitration model.
module tb_mod_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mod_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mod_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory contents seen by the responder, and the reference view of the same memory.
  logic [31:0] phys    [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction
  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Stimulus for one run and what was observed during it.
  bit          s_if, s_dm, s_dm_we, s_chain, s_c_we;
  logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata, s_c_addr, s_c_wdata;
  int          ep_cnt;
  logic [31:0] ep_addr [4];
  logic [31:0] ep_wdata[4];
  logic        ep_we   [4];
  bit          ep_hold [4];
  int          ep_start[4];
  int          ep_len  [4];
  int          dm_ack_n, if_ack_n, if_ack_cyc;
  int          dm_ack_cyc[4];
  logic [31:0] dm_rd[4];
  logic        dm_err[4];
  logic [31:0] if_rd;
  logic        if_err;

  // Drives requests, acts as the memory with fixed ack latency, and records events.
  task automatic run_txn(input int lat, input int max_cyc);
    bit active;
    int age;
    bit chain_left;
    active = 1'b0; age = 0; chain_left = s_chain;
    ep_cnt = 0; dm_ack_n = 0; if_ack_n = 0; if_ack_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      ep_hold[i] = 1'b1; ep_len[i] = 0; ep_start[i] = -1; dm_ack_cyc[i] = -1;
    end
    bus.if_req_i = s_if; bus.if_addr_i = s_if_addr;
    bus.dm_req_i = s_dm; bus.dm_we_i = s_dm_we;
    bus.dm_addr_i = s_dm_addr; bus.dm_wdata_i = s_dm_wdata;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (bus.dm_ack_o) begin
        if (dm_ack_n < 4) begin
          dm_ack_cyc[dm_ack_n] = c; dm_rd[dm_ack_n] = bus.dm_rdata_o; dm_err[dm_ack_n] = bus.dm_err_o;
        end
        dm_ack_n++;
        if (chain_left) begin
          chain_left = 1'b0;
          bus.dm_we_i = s_c_we; bus.dm_addr_i = s_c_addr; bus.dm_wdata_i = s_c_wdata;
        end else begin
          bus.dm_req_i = 1'b0;
        end
      end
      if (bus.if_ack_o) begin
        if_ack_n++; if_ack_cyc = c; if_rd = bus.if_rdata_o; if_err = bus.if_err_o;
        bus.if_req_i = 1'b0;
      end
      if (bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0; active = 1'b0;
      end else if (active && !bus.mem_req_o) begin
        active = 1'b0;
      end
      if (bus.mem_req_o) begin
        if (!active) begin
          if (ep_cnt < 4) begin
            ep_start[ep_cnt] = c; ep_addr[ep_cnt] = bus.mem_addr_o;
            ep_we[ep_cnt] = bus.mem_we_o; ep_wdata[ep_cnt] = bus.mem_wdata_o;
          end
          ep_cnt++; active = 1'b1; age = 0;
        end else begin
          age++;
          if (ep_cnt <= 4 && {bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o} !==
              {ep_addr[ep_cnt-1], ep_we[ep_cnt-1], ep_wdata[ep_cnt-1]}) ep_hold[ep_cnt-1] = 1'b0;
        end
        if (ep_cnt <= 4) ep_len[ep_cnt-1]++;
        if (age == lat) begin
          bus.mem_ack_i = 1'b1;
          if (bus.mem_we_o) begin
            phys[bus.mem_addr_o] = bus.mem_wdata_o;
            bus.mem_rdata_i = $urandom;
          end else begin
            bus.mem_rdata_i = phys_rd(bus.mem_addr_o);
          end
        end
      end
    end
    bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0; bus.mem_ack_i = 1'b0;
  endtask

  task automatic clear_stim();
    s_if = 1'b0; s_dm = 1'b0; s_dm_we = 1'b0; s_chain = 1'b0; s_c_we = 1'b0;
    s_if_addr = 32'h0; s_dm_addr = 32'h0; s_dm_wdata = 32'h0; s_c_addr = 32'h0; s_c_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0; bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0;
    bus.dm_addr_i = 32'h0; bus.dm_wdata_i = 32'h0; bus.mem_rdata_i = 32'h0; bus.mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_ack_o, bus.if_err_o,
         bus.if_rdata_o, bus.dm_ack_o, bus.dm_err_o, bus.dm_rdata_o, bus.busy_o} !== 135'h0)
      $display("FAIL reset_outputs got req=%b we=%b addr=%h busy=%b ifack=%b dmack=%b exp all 0",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.busy_o, bus.if_ack_o, bus.dm_ack_o);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    n_checks++;
    if ({bus.if_ack_o, bus.dm_ack_o, bus.if_rdata_o, bus.dm_rdata_o, bus.busy_o} !== 67'h0)
      $display("FAIL idle_ack_ignored got ifack=%b dmack=%b ifrd=%h dmrd=%h busy=%b exp all 0",
               bus.if_ack_o, bus.dm_ack_o, bus.if_rdata_o, bus.dm_rdata_o, bus.busy_o);
    else n_pass++;
    bus.mem_ack_i = 1'b0;
    exp_if_rdata = 32'h0; exp_dm_rdata = 32'h0;
  endtask

  task automatic test_fetch_only();
    phys[32'h10] = 32'h0000_0013; ref_mem[32'h10] = 32'h0000_0013;
    clear_stim(); s_if = 1'b1; s_if_addr = 32'h0000_0010;
    run_txn(3, 12);
    n_checks++;
    if ({ep_cnt, ep_addr[0], ep_we[0], ep_hold[0]} !== {32'd1, 32'h10, 1'b0, 1'b1})
      $display("FAIL fetch_issue got n=%0d addr=%h we=%b hold=%b exp 1/00000010/0/1", ep_cnt, ep_addr[0], ep_we[0], ep_hold[0]);
    else n_pass++;
    n_checks++;
    if ({ep_start[0], if_ack_cyc, if_ack_n, dm_ack_n} !== {32'd1, 32'd5, 32'd1, 32'd0})
      $display("FAIL fetch_timing got start=%0d ack=%0d nack=%0d ndm=%0d exp 1/5/1/0", ep_start[0], if_ack_cyc, if_ack_n, dm_ack_n);
    else n_pass++;
    n_checks++;
    if ({if_rd, if_err, bus.busy_o} !== {32'h13, 1'b0, 1'b0})
      $display("FAIL fetch_result got rdata=%h err=%b busy=%b exp 00000013/0/0", if_rd, if_err, bus.busy_o);
    else n_pass++;
    exp_if_rdata = 32'h13;
  endtask

  task automatic test_simultaneous();
    clear_stim();
    s_if = 1'b1; s_if_addr = 32'h100;
    s_dm = 1'b1; s_dm_we = 1'b1; s_dm_addr = 32'h100; s_dm_wdata = 32'hDEAD_BEEF;
    run_txn(2, 16);
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    n_checks++;
    if ({ep_cnt, ep_addr[0], ep_we[0], ep_wdata[0], ep_hold[0]} !== {32'd2, 32'h100, 1'b1, 32'hDEAD_BEEF, 1'b1})
      $display("FAIL simul_store_first got n=%0d addr=%h we=%b wd=%h exp 2/00000100/1/deadbeef", ep_cnt, ep_addr[0], ep_we[0], ep_wdata[0]);
    else n_pass++;
    n_checks++;
    if ({ep_addr[1], ep_we[1], ep_wdata[1], ep_hold[1]} !== {32'h100, 1'b0, 32'h0, 1'b1})
      $display("FAIL simul_fetch_second got addr=%h we=%b wd=%h exp 00000100/0/0", ep_addr[1], ep_we[1], ep_wdata[1]);
    else n_pass++;
    n_checks++;
    if ({dm_ack_cyc[0], ep_start[1], if_ack_cyc} !== {32'd4, 32'd5, 32'd8})
      $display("FAIL simul_timing got dmack=%0d ifstart=%0d ifack=%0d exp 4/5/8", dm_ack_cyc[0], ep_start[1], if_ack_cyc);
    else n_pass++;
    n_checks++;
    if ({if_rd, dm_rd[0], dm_err[0], if_err} !== {32'hDEAD_BEEF, exp_dm_rdata, 1'b0, 1'b0})
      $display("FAIL simul_data got ifrd=%h dmrd=%h exp deadbeef/%h", if_rd, dm_rd[0], exp_dm_rdata);
    else n_pass++;
    exp_if_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ld;
    ld = ref_rd(32'h200);
    clear_stim();
    s_dm = 1'b1; s_dm_we = 1'b0; s_dm_addr = 32'h200;
    s_chain = 1'b1; s_c_we = 1'b1; s_c_addr = 32'h204; s_c_wdata = $urandom;
    run_txn(1, 14);
    ref_mem[32'h204] = s_c_wdata;
    n_checks++;
    if ({ep_start[0], dm_ack_cyc[0], ep_start[1], dm_ack_cyc[1], dm_ack_n} !== {32'd1, 32'd3, 32'd5, 32'd7, 32'd2})
      $display("FAIL b2b_timing got s0=%0d a0=%0d s1=%0d a1=%0d n=%0d exp 1/3/5/7/2",
               ep_start[0], dm_ack_cyc[0], ep_start[1], dm_ack_cyc[1], dm_ack_n);
    else n_pass++;
    n_checks++;
    if ({ep_we[0], ep_addr[1], ep_we[1], ep_wdata[1]} !== {1'b0, 32'h204, 1'b1, s_c_wdata})
      $display("FAIL b2b_issue got we0=%b addr1=%h we1=%b wd1=%h exp 0/00000204/1/%h", ep_we[0], ep_addr[1], ep_we[1], ep_wdata[1], s_c_wdata);
    else n_pass++;
    n_checks++;
    if ({dm_rd[0], dm_rd[1], bus.dm_rdata_o} !== {ld, ld, ld})
      $display("FAIL b2b_rdata_hold got load=%h store=%h now=%h exp %h", dm_rd[0], dm_rd[1], bus.dm_rdata_o, ld);
    else n_pass++;
    exp_dm_rdata = ld;
  endtask

  task automatic test_timeout();
    clear_stim(); s_if = 1'b1; s_if_addr = 32'h300;
    run_txn(NEVER, 24);
    n_checks++;
    if ({ep_len[0], if_ack_cyc - ep_start[0], if_ack_n} !== {32'd16, 32'd16, 32'd1})
      $display("FAIL timeout_timing got len=%0d ackdelay=%0d nack=%0d exp 16/16/1", ep_len[0], if_ack_cyc - ep_start[0], if_ack_n);
    else n_pass++;
    n_checks++;
    if ({if_err, if_rd, bus.busy_o, bus.mem_req_o} !== {1'b1, 32'h0, 1'b0, 1'b0})
      $display("FAIL timeout_result got err=%b rdata=%h busy=%b req=%b exp 1/0/0/0", if_err, if_rd, bus.busy_o, bus.mem_req_o);
    else n_pass++;
    exp_if_rdata = 32'h0;
  endtask

  task automatic test_ack_at_timeout();
    clear_stim(); s_if = 1'b1; s_if_addr = 32'h304;
    run_txn(TMO - 1, 24);
    n_checks++;
    if ({ep_len[0], if_ack_cyc - ep_start[0], if_ack_n} !== {32'd16, 32'd16, 32'd1})
      $display("FAIL coincide_timing got len=%0d ackdelay=%0d nack=%0d exp 16/16/1", ep_len[0], if_ack_cyc - ep_start[0], if_ack_n);
    else n_pass++;
    n_checks++;
    if ({if_err, if_rd} !== {1'b0, ref_rd(32'h304)})
      $display("FAIL coincide_result got err=%b rdata=%h exp 0/%h", if_err, if_rd, ref_rd(32'h304));
    else n_pass++;
    exp_if_rdata = ref_rd(32'h304);
  endtask

  task automatic test_reset_mid_access();
    bit spurious;
    @(negedge clk);
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h500; bus.dm_wdata_i = 32'h1234_5678;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o} !== {1'b1, 1'b1, 1'b1, 32'h500})
      $display("FAIL rstmid_busy got busy=%b req=%b we=%b addr=%h exp 1/1/1/00000500", bus.busy_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o);
    else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_ack_o, bus.if_err_o,
         bus.if_rdata_o, bus.dm_ack_o, bus.dm_err_o, bus.dm_rdata_o, bus.busy_o} !== 135'h0)
      $display("FAIL rstmid_async got req=%b we=%b addr=%h wd=%h ifrd=%h dmrd=%h busy=%b exp all 0", bus.mem_req_o,
               bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.dm_rdata_o, bus.busy_o);
    else n_pass++;
    bus.dm_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.dm_ack_o || bus.busy_o) spurious = 1'b1;
    end
    n_checks++;
    if (spurious !== 1'b0) $display("FAIL rstmid_no_ack got spurious=%b exp 0", spurious);
    else n_pass++;
    exp_if_rdata = 32'h0; exp_dm_rdata = 32'h0;
    clear_stim(); s_dm = 1'b1; s_dm_addr = 32'h400;
    run_txn(2, 10);
    n_checks++;
    if ({dm_ack_n, dm_rd[0], dm_err[0]} !== {32'd1, ref_rd(32'h400), 1'b0})
      $display("FAIL rstmid_fresh got n=%0d rdata=%h err=%b exp 1/%h/0", dm_ack_n, dm_rd[0], dm_err[0], ref_rd(32'h400));
    else n_pass++;
    exp_dm_rdata = ref_rd(32'h400);
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int mode, lat, t, dur, k, n_exp;
      bit to;
      clear_stim();
      mode = $urandom_range(0, 2);
      s_if = (mode != 1); s_dm = (mode != 0);
      s_if_addr  = 32'h1000 + ($urandom_range(0, 7) << 2);
      s_dm_addr  = 32'h1000 + ($urandom_range(0, 7) << 2);
      s_dm_we    = $urandom_range(0, 1);
      s_dm_wdata = $urandom;
      lat = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(1, 4);
      run_txn(lat, 45);
      // Served in priority order, each taking lat+1 busy cycles or TMO on abort.
      to  = (lat >= TMO);
      dur = to ? TMO : lat + 1;
      n_exp = int'(s_if) + int'(s_dm);
      t = 1; k = 0;
      n_checks++;
      if (ep_cnt !== n_exp) $display("FAIL rnd%0d_count got %0d exp %0d", it, ep_cnt, n_exp);
      else n_pass++;
      if (s_dm) begin
        if (to) exp_dm_rdata = 32'h0;
        else if (s_dm_we) ref_mem[s_dm_addr] = s_dm_wdata;
        else exp_dm_rdata = ref_rd(s_dm_addr);
        n_checks++;
        if ({ep_addr[k], ep_we[k], ep_wdata[k], ep_hold[k]} !== {s_dm_addr, s_dm_we, s_dm_wdata, 1'b1})
          $display("FAIL rnd%0d_dm_issue got addr=%h we=%b wd=%h hold=%b exp %h/%b/%h/1", it,
                   ep_addr[k], ep_we[k], ep_wdata[k], ep_hold[k], s_dm_addr, s_dm_we, s_dm_wdata);
        else n_pass++;
        n_checks++;
        if ({ep_start[k], dm_ack_cyc[0], dm_ack_n} !== {t, t + dur, 32'd1})
          $display("FAIL rnd%0d_dm_timing got start=%0d ack=%0d n=%0d exp %0d/%0d/1", it, ep_start[k], dm_ack_cyc[0], dm_ack_n, t, t + dur);
        else n_pass++;
        n_checks++;
        if ({dm_rd[0], dm_err[0]} !== {exp_dm_rdata, to})
          $display("FAIL rnd%0d_dm_result got rdata=%h err=%b exp %h/%b", it, dm_rd[0], dm_err[0], exp_dm_rdata, to);
        else n_pass++;
        t = t + dur + 1; k = 1;
      end
      if (s_if) begin
        exp_if_rdata = to ? 32'h0 : ref_rd(s_if_addr);
        n_checks++;
        if ({ep_addr[k], ep_we[k], ep_wdata[k], ep_hold[k]} !== {s_if_addr, 1'b0, 32'h0, 1'b1})
          $display("FAIL rnd%0d_if_issue got addr=%h we=%b wd=%h hold=%b exp %h/0/0/1", it,
                   ep_addr[k], ep_we[k], ep_wdata[k], ep_hold[k], s_if_addr);
        else n_pass++;
        n_checks++;
        if ({ep_start[k], if_ack_cyc, if_ack_n} !== {t, t + dur, 32'd1})
          $display("FAIL rnd%0d_if_timing got start=%0d ack=%0d n=%0d exp %0d/%0d/1", it, ep_start[k], if_ack_cyc, if_ack_n, t, t + dur);
        else n_pass++;
        n_checks++;
        if ({if_rd, if_err} !== {exp_if_rdata, to})
          $display("FAIL rnd%0d_if_result got rdata=%h err=%b exp %h/%b", it, if_rd, if_err, exp_if_rdata, to);
        else n_pass++;
      end
      n_checks++;
      if ({bus.if_rdata_o, bus.dm_rdata_o, bus.busy_o} !== {exp_if_rdata, exp_dm_rdata, 1'b0})
        $display("FAIL rnd%0d_hold got ifrd=%h dmrd=%h busy=%b exp %h/%h/0", it,
                 bus.if_rdata_o, bus.dm_rdata_o, bus.busy_o, exp_if_rdata, exp_dm_rdata);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
